// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer: takes one register-file command at a time, gains the
// shared bus, reads up to two operands, optionally waits for a write-back
// value and writes it to rd, then reports completion (and errors) with a
// one-cycle pulse.
module reg_bus_sequencer #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_ADDR   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_rs1,
  input  logic [ADDR_WIDTH-1:0] cmd_rs2,
  input  logic [ADDR_WIDTH-1:0] cmd_rd,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic                  rf_wrt,
  output logic                  rf_en,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_drive,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  wb_valid,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] rs1_val,
  output logic [DATA_WIDTH-1:0] rs2_val,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    EXEC = 3'd4,
    WR   = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [1:0] OpRead1     = 2'b00;
  localparam logic [1:0] OpRead2     = 2'b01;
  localparam logic [1:0] OpReadWrite = 2'b10;

  localparam logic [ADDR_WIDTH-1:0] MaxAddr = ADDR_WIDTH'(MAX_ADDR);

  state_t                  state_q, state_d;
  logic [1:0]              op_q;
  logic [ADDR_WIDTH-1:0]   rs1_q, rs2_q, rd_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   rs1_val_q, rs2_val_q, wdata_q;

  logic                    cmd_bad;
  logic                    accept;
  logic                    cap_rs1, cap_rs2, cap_wb;

  // Address check on the incoming command: only addresses the op actually uses count.
  always_comb begin
    cmd_bad = 1'b0;
    case (cmd_op)
      OpRead1:     cmd_bad = (cmd_rs1 > MaxAddr);
      OpRead2:     cmd_bad = (cmd_rs1 > MaxAddr) || (cmd_rs2 > MaxAddr);
      OpReadWrite: cmd_bad = (cmd_rs1 > MaxAddr) || (cmd_rs2 > MaxAddr) ||
                             (cmd_rd > MaxAddr);
      default:     cmd_bad = (cmd_rd > MaxAddr);
    endcase
  end

  // Next-state and output decode; all bus/register-file strobes are gated by the grant.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    cap_rs1   = 1'b0;
    cap_rs2   = 1'b0;
    cap_wb    = 1'b0;
    cmd_ready = 1'b0;
    bus_req   = 1'b0;
    rf_addr   = '0;
    rf_wrt    = 1'b0;
    rf_en     = 1'b0;
    bus_drive = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = reset;
        if (cmd_valid && reset) begin
          accept  = 1'b1;
          state_d = cmd_bad ? DONE : REQ;
        end
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          state_d = (op_q == 2'b11) ? EXEC : RD1;
        end
      end
      RD1: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          rf_en   = 1'b1;
          rf_addr = rs1_q;
          cap_rs1 = 1'b1;
          state_d = (op_q == OpRead1) ? DONE : RD2;
        end
      end
      RD2: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          rf_en   = 1'b1;
          rf_addr = rs2_q;
          cap_rs2 = 1'b1;
          state_d = (op_q == OpRead2) ? DONE : EXEC;
        end
      end
      EXEC: begin
        bus_req = 1'b1;
        if (wb_valid) begin
          cap_wb  = 1'b1;
          state_d = (rd_q == '0) ? DONE : WR;
        end
      end
      WR: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          rf_en     = 1'b1;
          rf_wrt    = 1'b1;
          rf_addr   = rd_q;
          bus_drive = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops straight to IDLE so every strobe falls with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latch on the handshake, including whether it failed the address check.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      op_q  <= cmd_op;
      rs1_q <= cmd_rs1;
      rs2_q <= cmd_rs2;
      rd_q  <= cmd_rd;
      err_q <= cmd_bad;
    end
  end

  // Operand and write-back capture; values persist until the next granted read or write-back.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      wdata_q   <= '0;
    end else begin
      if (cap_rs1) rs1_val_q <= bus_rdata;
      if (cap_rs2) rs2_val_q <= bus_rdata;
      if (cap_wb)  wdata_q   <= wb_data;
    end
  end

  assign rs1_val   = rs1_val_q;
  assign rs2_val   = rs2_val_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// tb_reg_bus_sequencer: drives reg_bus_sequencer against a small register-file
// model sitting on the shared bus, using a table of directed commands plus
// hand-written grant-loss and reset-during-write sequences.
module tb_reg_bus_sequencer;

  logic        clock = 1'b0;
  logic        resetN;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOp;
  logic [5:0]  cmdRs1, cmdRs2, cmdRd;
  logic        busReq;
  logic        busGnt;
  logic [5:0]  rfAddr;
  logic        rfWrt;
  logic        rfEn;
  logic [31:0] busRdata;
  logic        busDrive;
  logic [31:0] busWdata;
  logic        wbValid;
  logic [31:0] wbData;
  logic [31:0] rs1Val, rs2Val;
  logic        done;
  logic        err;

  logic [31:0] rf [0:63];

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    int          wbAt;
    logic [31:0] wbVal;
    int          gntOffAt;
    int          gntOffLen;
    int          expLat;
    logic        expErr;
    logic [31:0] expRs1;
    logic [31:0] expRs2;
    int          expWrites;
    logic [5:0]  expWrAddr;
    int          expBusReq;
    int          expRfEn;
  } vec_t;

  vec_t vecs[15];

  int          obsLat, obsBusReq, obsRfEn, obsWrites, obsViol;
  logic        obsErr, obsReadyAtIssue, obsReadyAfter, obsDoneAfter;
  logic [5:0]  obsWrAddr;
  logic [31:0] obsWrData;

  reg_bus_sequencer #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .MAX_ADDR(32)) dut (
    .clock     (clock),
    .reset     (resetN),
    .cmd_valid (cmdValid),
    .cmd_ready (cmdReady),
    .cmd_op    (cmdOp),
    .cmd_rs1   (cmdRs1),
    .cmd_rs2   (cmdRs2),
    .cmd_rd    (cmdRd),
    .bus_req   (busReq),
    .bus_gnt   (busGnt),
    .rf_addr   (rfAddr),
    .rf_wrt    (rfWrt),
    .rf_en     (rfEn),
    .bus_rdata (busRdata),
    .bus_drive (busDrive),
    .bus_wdata (busWdata),
    .wb_valid  (wbValid),
    .wb_data   (wbData),
    .rs1_val   (rs1Val),
    .rs2_val   (rs2Val),
    .done      (done),
    .err       (err)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  // Register file answers granted reads; otherwise the bus floats to a recognisable junk value.
  assign busRdata = (rfEn && !rfWrt) ? rf[rfAddr] : 32'h5A5A_5A5A;

  // Register-file model: preloaded once, then takes a write on any clock edge with a write strobe.
  initial begin
    for (int i = 0; i < 64; i++) rf[i] = 32'hEE00_0000 | i;
    rf[0]  = 32'h0000_0000;
    rf[3]  = 32'h0000_0033;
    rf[5]  = 32'h0000_0011;
    rf[7]  = 32'h0000_0022;
    rf[10] = 32'h0000_00A0;
    rf[32] = 32'h0000_0032;
    forever begin
      @(posedge clock);
      if (rfEn && rfWrt) rf[rfAddr] = busWdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic issueCmd(input logic [1:0] op, input logic [5:0] rs1,
                          input logic [5:0] rs2, input logic [5:0] rd);
    cmdOp    = op;
    cmdRs1   = rs1;
    cmdRs2   = rs2;
    cmdRd    = rd;
    cmdValid = 1'b1;
    #1;
    obsReadyAtIssue = cmdReady;
    stepCycle();
    cmdValid = 1'b0;
  endtask

  // Runs one table command to completion (bounded), recording what the bus saw.
  task automatic applyStimulus(input vec_t v);
    int  c;
    bit  seenDone;
    busGnt    = 1'b1;
    wbValid   = 1'b0;
    obsLat    = -1;
    obsErr    = 1'b0;
    obsBusReq = 0;
    obsRfEn   = 0;
    obsWrites = 0;
    obsViol   = 0;
    obsWrAddr = '0;
    obsWrData = '0;
    issueCmd(v.op, v.rs1, v.rs2, v.rd);
    c = 1;
    seenDone = 0;
    while (!seenDone && c <= 40) begin
      busGnt  = !(c >= v.gntOffAt && c < v.gntOffAt + v.gntOffLen);
      wbValid = (c >= v.wbAt);
      wbData  = wbValid ? v.wbVal : 32'hBAAD_F00D;
      #1;
      if (busReq) obsBusReq++;
      if (rfEn) obsRfEn++;
      if (rfEn && rfWrt) begin
        obsWrites++;
        obsWrAddr = rfAddr;
        obsWrData = busWdata;
      end
      if (!rfEn && (rfAddr != 6'd0 || rfWrt)) obsViol++;
      if (busDrive != (rfEn && rfWrt)) obsViol++;
      if (err && !done) obsViol++;
      if (cmdReady) obsViol++;
      if (done) begin
        seenDone = 1;
        obsLat   = c;
        obsErr   = err;
      end else begin
        @(posedge clock);
        #1;
        c++;
      end
    end
    stepCycle();
    busGnt  = 1'b1;
    wbValid = 1'b0;
    #1;
    obsReadyAfter = cmdReady;
    obsDoneAfter  = done;
  endtask

  initial begin
    logic [31:0] oldR3;

    resetN   = 1'b0;
    cmdValid = 1'b0;
    cmdOp    = '0;
    cmdRs1   = '0;
    cmdRs2   = '0;
    cmdRd    = '0;
    busGnt   = 1'b0;
    wbValid  = 1'b0;
    wbData   = '0;

    //          op     rs1    rs2    rd     wbAt wbVal         gOff gLen lat err rs1          rs2          wr wrAd  brq rfen
    vecs[0]  = '{2'b00, 6'd5,  6'd7,  6'd0,  1, 32'h0,         0, 0,  3, 1'b0, 32'h11,       32'h0,       0, 6'd0,  2, 1};
    vecs[1]  = '{2'b01, 6'd5,  6'd7,  6'd0,  1, 32'h0,         0, 0,  4, 1'b0, 32'h11,       32'h22,      0, 6'd0,  3, 2};
    vecs[2]  = '{2'b10, 6'd10, 6'd32, 6'd3,  6, 32'hDEADBEEF,  0, 0,  8, 1'b0, 32'hA0,       32'h32,      1, 6'd3,  7, 3};
    vecs[3]  = '{2'b11, 6'd0,  6'd0,  6'd0,  2, 32'h55,        0, 0,  3, 1'b0, 32'hA0,       32'h32,      0, 6'd0,  2, 0};
    vecs[4]  = '{2'b00, 6'd40, 6'd0,  6'd0,  1, 32'h0,         0, 0,  1, 1'b1, 32'hA0,       32'h32,      0, 6'd0,  0, 0};
    vecs[5]  = '{2'b11, 6'd0,  6'd0,  6'd32, 2, 32'h12345678,  0, 0,  4, 1'b0, 32'hA0,       32'h32,      1, 6'd32, 3, 1};
    vecs[6]  = '{2'b01, 6'd33, 6'd0,  6'd0,  1, 32'h0,         0, 0,  1, 1'b1, 32'hA0,       32'h32,      0, 6'd0,  0, 0};
    vecs[7]  = '{2'b01, 6'd3,  6'd0,  6'd0,  1, 32'h0,         0, 0,  4, 1'b0, 32'hDEADBEEF, 32'h0,       0, 6'd0,  3, 2};
    vecs[8]  = '{2'b10, 6'd5,  6'd7,  6'd0,  5, 32'h77,        0, 0,  6, 1'b0, 32'h11,       32'h22,      0, 6'd0,  5, 2};
    vecs[9]  = '{2'b11, 6'd0,  6'd0,  6'd33, 1, 32'h0,         0, 0,  1, 1'b1, 32'h11,       32'h22,      0, 6'd0,  0, 0};
    vecs[10] = '{2'b10, 6'd5,  6'd7,  6'd40, 1, 32'h0,         0, 0,  1, 1'b1, 32'h11,       32'h22,      0, 6'd0,  0, 0};
    vecs[11] = '{2'b00, 6'd32, 6'd0,  6'd0,  1, 32'h0,         1, 2,  5, 1'b0, 32'h12345678, 32'h22,      0, 6'd0,  4, 1};
    vecs[12] = '{2'b11, 6'd0,  6'd0,  6'd3,  2, 32'hCAFE0001,  3, 2,  6, 1'b0, 32'h12345678, 32'h22,      1, 6'd3,  5, 1};
    vecs[13] = '{2'b01, 6'd7,  6'd0,  6'd63, 1, 32'h0,         0, 0,  4, 1'b0, 32'h22,       32'h0,       0, 6'd0,  3, 2};
    vecs[14] = '{2'b00, 6'd0,  6'd63, 6'd63, 1, 32'h0,         0, 0,  3, 1'b0, 32'h0,        32'h0,       0, 6'd0,  2, 1};

    // Reset state
    #3;
    checkOutput("reset_cmd_ready", {31'd0, cmdReady}, 32'd0);
    checkOutput("reset_strobes", {26'd0, busReq, rfEn, rfWrt, busDrive, done, err}, 32'd0);
    checkOutput("reset_rf_addr", {26'd0, rfAddr}, 32'd0);
    checkOutput("reset_regs", rs1Val | rs2Val | busWdata, 32'd0);
    #9;
    resetN = 1'b1;
    #1;
    checkOutput("reset_release_ready", {31'd0, cmdReady}, 32'd1);
    stepCycle();

    // Table-driven commands
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_ready_at_issue", i), {31'd0, obsReadyAtIssue}, 32'd1);
      checkOutput($sformatf("v%0d_latency", i), obsLat, vecs[i].expLat);
      checkOutput($sformatf("v%0d_err", i), {31'd0, obsErr}, {31'd0, vecs[i].expErr});
      checkOutput($sformatf("v%0d_rs1_val", i), rs1Val, vecs[i].expRs1);
      checkOutput($sformatf("v%0d_rs2_val", i), rs2Val, vecs[i].expRs2);
      checkOutput($sformatf("v%0d_writes", i), obsWrites, vecs[i].expWrites);
      checkOutput($sformatf("v%0d_bus_req_cycles", i), obsBusReq, vecs[i].expBusReq);
      checkOutput($sformatf("v%0d_rf_en_cycles", i), obsRfEn, vecs[i].expRfEn);
      checkOutput($sformatf("v%0d_invariants", i), obsViol, 32'd0);
      checkOutput($sformatf("v%0d_ready_after", i), {31'd0, obsReadyAfter}, 32'd1);
      checkOutput($sformatf("v%0d_done_one_cycle", i), {31'd0, obsDoneAfter}, 32'd0);
      if (vecs[i].expWrites != 0) begin
        checkOutput($sformatf("v%0d_wr_addr", i), {26'd0, obsWrAddr}, {26'd0, vecs[i].expWrAddr});
        checkOutput($sformatf("v%0d_wr_data", i), obsWrData, vecs[i].wbVal);
        checkOutput($sformatf("v%0d_rf_written", i), rf[vecs[i].expWrAddr], vecs[i].wbVal);
      end
    end

    // Grant lost for three cycles while in RD2
    busGnt = 1'b1;
    issueCmd(2'b01, 6'd7, 6'd5, 6'd0);
    stepCycle();
    stepCycle();
    for (int k = 0; k < 3; k++) begin
      busGnt = 1'b0;
      #1;
      checkOutput($sformatf("gnt_hold%0d_rf_en", k), {31'd0, rfEn}, 32'd0);
      checkOutput($sformatf("gnt_hold%0d_rf_addr", k), {26'd0, rfAddr}, 32'd0);
      checkOutput($sformatf("gnt_hold%0d_bus_req", k), {31'd0, busReq}, 32'd1);
      stepCycle();
      checkOutput($sformatf("gnt_hold%0d_rs2_val", k), rs2Val, 32'h0);
      checkOutput($sformatf("gnt_hold%0d_done", k), {31'd0, done}, 32'd0);
    end
    busGnt = 1'b1;
    #1;
    checkOutput("gnt_resume_rf_en", {31'd0, rfEn}, 32'd1);
    checkOutput("gnt_resume_rf_addr", {26'd0, rfAddr}, 32'd5);
    stepCycle();
    checkOutput("gnt_resume_done", {30'd0, done, err}, 32'd2);
    checkOutput("gnt_resume_rs1_val", rs1Val, 32'h22);
    checkOutput("gnt_resume_rs2_val", rs2Val, 32'h11);
    stepCycle();

    // Reset asserted in the middle of a write cycle
    oldR3 = rf[3];
    issueCmd(2'b11, 6'd0, 6'd0, 6'd3);
    stepCycle();
    wbValid = 1'b1;
    wbData  = 32'h0BAD_0BAD;
    stepCycle();
    wbValid = 1'b0;
    #1;
    checkOutput("wr_before_reset_rf_en", {30'd0, rfEn, rfWrt}, 32'd3);
    checkOutput("wr_before_reset_bus_drive", {31'd0, busDrive}, 32'd1);
    resetN = 1'b0;
    #1;
    checkOutput("wr_reset_strobes", {28'd0, rfEn, rfWrt, busDrive, busReq}, 32'd0);
    checkOutput("wr_reset_bus_wdata", busWdata, 32'd0);
    checkOutput("wr_reset_cmd_ready", {31'd0, cmdReady}, 32'd0);
    stepCycle();
    stepCycle();
    checkOutput("wr_reset_rf_unchanged", rf[3], oldR3);
    resetN = 1'b1;
    #1;
    checkOutput("wr_reset_idle_ready", {30'd0, cmdReady, done}, 32'd2);
    stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
